// File: rtl/vertical_node_pkg.sv
// Shared definitions for the multi-channel vertical adder node.
package vertical_node_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'b00,
    MODE_ADD     = 2'b01,
    MODE_ACC     = 2'b10,
    MODE_ADD_ALT = 2'b11
  } mode_e;

  // Widest lane the helper functions support.
  localparam int unsigned MaxW = 64;

  // Largest positive two's complement value of width w, in the low w bits.
  function automatic logic [MaxW-1:0] smax(int unsigned w);
    return (MaxW'(1) << (w - 1)) - MaxW'(1);
  endfunction

  // Most negative two's complement value of width w, in the low w bits.
  function automatic logic [MaxW-1:0] smin(int unsigned w);
    return MaxW'(1) << (w - 1);
  endfunction

  // Signed overflow: operands agree in sign and the sum disagrees.
  function automatic logic signed_ovf(logic sign_a, logic sign_b, logic sign_s);
    return (sign_a == sign_b) && (sign_s != sign_a);
  endfunction

endpackage

// File: rtl/vertical_node_mc_lane_add.sv
// One combinational lane adder: res = a + (en ? b : 0), wrapping or saturating.
module vertical_lane_add
  import vertical_node_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter bit          SAT = 1'b1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         en_i,
  output logic [W-1:0] res_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] MaxV = W'(smax(W));
  localparam logic [W-1:0] MinV = W'(smin(W));

  logic [W-1:0] b_eff;
  logic [W-1:0] sum;

  // Masked add, overflow detect, optional clamp toward the sign of the operands.
  always_comb begin
    b_eff = en_i ? b_i : '0;
    sum   = a_i + b_eff;
    ovf_o = signed_ovf(a_i[W-1], b_eff[W-1], sum[W-1]);
    res_o = sum;
    if (SAT && ovf_o) begin
      res_o = a_i[W-1] ? MinV : MaxV;
    end
  end

endmodule

// File: rtl/vertical_node_mc.sv
// Multi-channel vertical adder node: per-lane top + masked mux product, with
// PASS / ADD / ACC modes, registered lane enables and sticky overflow flags.
module vertical_node_mc
  import vertical_node_pkg::*;
#(
  parameter int unsigned F_WIDTH = 8,
  parameter int unsigned I_WIDTH = 8,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ACC_LEN = 4,
  parameter bit          SAT     = 1'b1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_CH*(I_WIDTH+F_WIDTH)-1:0] top_data_i,
  input  logic [NUM_CH*(I_WIDTH+F_WIDTH)-1:0] mux_data_i,
  input  logic                                in_valid_i,
  input  logic [1:0]                          mode_i,
  input  logic [NUM_CH-1:0]                   en_lane_i,
  input  logic                                en_ld_i,
  input  logic                                acc_clr_i,
  input  logic                                ovf_clr_i,
  output logic [NUM_CH-1:0]                   en_lane_o,
  output logic [NUM_CH*(I_WIDTH+F_WIDTH)-1:0] out_data_o,
  output logic                                out_valid_o,
  output logic [NUM_CH-1:0]                   ovf_o,
  output logic                                acc_busy_o
);

  localparam int unsigned W    = I_WIDTH + F_WIDTH;
  localparam int unsigned CntW = $clog2(ACC_LEN);
  localparam logic [CntW-1:0] LastBeat = CntW'(ACC_LEN - 1);

  logic [NUM_CH-1:0]   en_q, en_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  mode_e               mode_q, mode_d;
  logic [NUM_CH*W-1:0] acc_q, acc_d;
  logic [NUM_CH*W-1:0] out_q, out_d;
  logic                vld_q, vld_d;
  logic [NUM_CH-1:0]   ovf_q, ovf_d;

  logic [NUM_CH*W-1:0] lane_a;
  logic [NUM_CH*W-1:0] lane_res;
  logic [NUM_CH-1:0]   lane_ovf;
  logic [NUM_CH-1:0]   new_ovf;
  logic                first_beat;
  mode_e               mode_eff;
  logic                is_pass;
  logic                is_acc;

  // Mode is taken live on the first beat and from the latch for the rest of a reduction.
  always_comb begin
    first_beat = (cnt_q == '0);
    mode_eff   = first_beat ? mode_e'(mode_i) : mode_q;
    is_pass    = (mode_eff == MODE_PASS);
    is_acc     = (mode_eff == MODE_ACC);
    lane_a     = first_beat ? top_data_i : acc_q;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    vertical_lane_add #(
      .W   (W),
      .SAT (SAT)
    ) u_lane (
      .a_i   (lane_a[k*W +: W]),
      .b_i   (mux_data_i[k*W +: W]),
      .en_i  (en_q[k]),
      .res_o (lane_res[k*W +: W]),
      .ovf_o (lane_ovf[k])
    );
  end

  // Next-state: enables, mode latch, beat counter, accumulators, output and flags.
  always_comb begin
    en_d    = en_ld_i ? en_lane_i : en_q;
    cnt_d   = cnt_q;
    mode_d  = first_beat ? mode_eff : mode_q;
    acc_d   = acc_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    new_ovf = '0;
    if (acc_clr_i) begin
      cnt_d = '0;
      acc_d = '0;
    end
    // A clear coinciding with an ACC beat drops that beat.
    if (in_valid_i && !(acc_clr_i && is_acc)) begin
      if (is_pass) begin
        out_d = top_data_i;
        vld_d = 1'b1;
      end else if (!is_acc) begin
        out_d   = lane_res;
        vld_d   = 1'b1;
        new_ovf = lane_ovf;
      end else begin
        new_ovf = lane_ovf;
        if (cnt_q == LastBeat) begin
          out_d = lane_res;
          vld_d = 1'b1;
          cnt_d = '0;
          acc_d = '0;
        end else begin
          acc_d = lane_res;
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end
    // A new overflow wins over a same-cycle clear.
    ovf_d = (ovf_clr_i ? '0 : ovf_q) | new_ovf;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q   <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_PASS;
      acc_q  <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= '0;
    end else begin
      en_q   <= en_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

  assign en_lane_o   = en_q;
  assign out_data_o  = out_q;
  assign out_valid_o = vld_q;
  assign ovf_o       = ovf_q;
  assign acc_busy_o  = (cnt_q != '0);

endmodule

// File: tb/tb_vertical_node_mc.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// integer-arithmetic reference model, on a saturating and a wrapping instance.
module tb_vertical_node_mc;

  localparam int W  = 16;
  localparam int NC = 4;
  localparam int AL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC*W-1:0] top, mux;
  logic          in_valid;
  logic [1:0]    mode;
  logic [NC-1:0] en_lane;
  logic          en_ld, acc_clr, ovf_clr;

  logic [NC-1:0]   en_s, en_w, ovf_s, ovf_w;
  logic [NC*W-1:0] out_s, out_w;
  logic            vld_s, vld_w, busy_s, busy_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vertical_node_mc #(
    .F_WIDTH (8), .I_WIDTH (8), .NUM_CH (NC), .ACC_LEN (AL), .SAT (1'b1)
  ) dut (
    .clk_i (clk), .rst_i (rst), .top_data_i (top), .mux_data_i (mux),
    .in_valid_i (in_valid), .mode_i (mode), .en_lane_i (en_lane), .en_ld_i (en_ld),
    .acc_clr_i (acc_clr), .ovf_clr_i (ovf_clr), .en_lane_o (en_s), .out_data_o (out_s),
    .out_valid_o (vld_s), .ovf_o (ovf_s), .acc_busy_o (busy_s)
  );

  vertical_node_mc #(
    .F_WIDTH (8), .I_WIDTH (8), .NUM_CH (NC), .ACC_LEN (AL), .SAT (1'b0)
  ) dut_w (
    .clk_i (clk), .rst_i (rst), .top_data_i (top), .mux_data_i (mux),
    .in_valid_i (in_valid), .mode_i (mode), .en_lane_i (en_lane), .en_ld_i (en_ld),
    .acc_clr_i (acc_clr), .ovf_clr_i (ovf_clr), .en_lane_o (en_w), .out_data_o (out_w),
    .out_valid_o (vld_w), .ovf_o (ovf_w), .acc_busy_o (busy_w)
  );

  // ---------------- reference model ----------------
  logic [NC-1:0]   m_en;
  logic [NC-1:0]   m_ovf [2];
  logic [NC*W-1:0] m_out [2];
  logic            m_vld;
  int              m_cnt;
  int              m_mode;
  int              m_acc [2][NC];

  function automatic int sx(logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // Exact sum reduced to a W-bit signed result, saturated or wrapped.
  function automatic int fix(int s, int sat, output bit o);
    o = (s > 32767) || (s < -32768);
    if (!o) return s;
    if (sat != 0) return (s > 0) ? 32767 : -32768;
    return sx(W'(s));
  endfunction

  always @(posedge clk) begin
    int  md, t, b, a, r;
    bit  o, fin, drop;
    if (rst) begin
      m_en = '0; m_vld = 1'b0; m_cnt = 0; m_mode = 0;
      for (int s = 0; s < 2; s++) begin
        m_ovf[s] = '0; m_out[s] = '0;
        for (int k = 0; k < NC; k++) m_acc[s][k] = 0;
      end
    end else begin
      md = (m_cnt == 0) ? ((mode == 2'd3) ? 1 : int'(mode)) : m_mode;
      m_mode = md;
      m_vld  = 1'b0;
      drop   = acc_clr && (md == 2);
      fin    = (md == 2) && (m_cnt == AL - 1);
      if (ovf_clr) begin
        m_ovf[0] = '0; m_ovf[1] = '0;
      end
      if (acc_clr) begin
        m_cnt = 0;
        for (int s = 0; s < 2; s++) for (int k = 0; k < NC; k++) m_acc[s][k] = 0;
      end
      if (in_valid && !drop) begin
        for (int s = 0; s < 2; s++) begin
          for (int k = 0; k < NC; k++) begin
            t = sx(top[k*W +: W]);
            b = m_en[k] ? sx(mux[k*W +: W]) : 0;
            o = 1'b0;
            if (md == 0) r = t;
            else if (md == 1) r = fix(t + b, 1 - s, o);
            else begin
              a = (m_cnt == 0) ? t : m_acc[s][k];
              r = fix(a + b, 1 - s, o);
            end
            if (o) m_ovf[s][k] = 1'b1;
            if (md != 2 || fin) m_out[s][k*W +: W] = W'(r);
            else m_acc[s][k] = r;
            if (fin) m_acc[s][k] = 0;
          end
        end
        if (md != 2 || fin) m_vld = 1'b1;
        if (md == 2) m_cnt = fin ? 0 : m_cnt + 1;
      end
      if (en_ld) m_en = en_lane;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; en_ld = 1'b0; acc_clr = 1'b0; ovf_clr = 1'b0;
  endtask

  function automatic logic [NC*W-1:0] rep(logic [W-1:0] v);
    return {v, v, v, v};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; idle(); top = '0; mux = '0; mode = 2'd0; en_lane = '0;
    tick(); tick();
    n_checks++;
    if ({out_s, vld_s, ovf_s, en_s, busy_s} !== '0) begin
      n_fail++; $display("FAIL reset_sat: got %h expected 0", {out_s, vld_s, ovf_s, en_s, busy_s});
    end
    n_checks++;
    if ({out_w, vld_w, ovf_w, en_w, busy_w} !== '0) begin
      n_fail++; $display("FAIL reset_wrap: got %h expected 0", {out_w, vld_w, ovf_w, en_w, busy_w});
    end
    rst = 1'b0;
  endtask

  task automatic test_add_basic();
    logic [NC*W-1:0] exp;
    en_ld = 1'b1; en_lane = 4'b1010; tick();
    en_ld = 1'b0; en_lane = 4'b0000;
    n_checks++;
    if (en_s !== 4'b1010) begin
      n_fail++; $display("FAIL en_load: got %b expected 1010", en_s);
    end
    mode = 2'd1; in_valid = 1'b1;
    top = {16'h0010, 16'h0002, 16'h0100, 16'h1234};
    mux = {16'h0001, 16'h0003, 16'h0080, 16'h0055};
    exp = {16'h0011, 16'h0002, 16'h0180, 16'h1234};
    tick(); in_valid = 1'b0;
    n_checks++;
    if (out_s !== exp || vld_s !== 1'b1) begin
      n_fail++; $display("FAIL add_basic: got %h/%b expected %h/1", out_s, vld_s, exp);
    end
    n_checks++;
    if (out_w !== exp) begin
      n_fail++; $display("FAIL add_basic_wrap: got %h expected %h", out_w, exp);
    end
    top = '1; tick();
    n_checks++;
    if (vld_s !== 1'b0 || out_s !== exp) begin
      n_fail++; $display("FAIL add_pulse_hold: got %h/%b expected %h/0", out_s, vld_s, exp);
    end
  endtask

  task automatic test_overflow();
    en_ld = 1'b1; en_lane = 4'b1111; tick(); en_ld = 1'b0;
    mode = 2'd1; in_valid = 1'b1;
    top = {48'h0, 16'h7F00}; mux = {48'h0, 16'h0200};
    tick(); in_valid = 1'b0;
    n_checks++;
    if (out_s[15:0] !== 16'h7FFF || ovf_s !== 4'b0001) begin
      n_fail++; $display("FAIL ovf_sat: got %h/%b expected 7fff/0001", out_s[15:0], ovf_s);
    end
    n_checks++;
    if (out_w[15:0] !== 16'h8100 || ovf_w !== 4'b0001) begin
      n_fail++; $display("FAIL ovf_wrap: got %h/%b expected 8100/0001", out_w[15:0], ovf_w);
    end
    tick(); tick();
    n_checks++;
    if (ovf_s !== 4'b0001) begin
      n_fail++; $display("FAIL ovf_sticky: got %b expected 0001", ovf_s);
    end
    in_valid = 1'b1; ovf_clr = 1'b1; tick();
    n_checks++;
    if (ovf_s !== 4'b0001 || ovf_w !== 4'b0001) begin
      n_fail++; $display("FAIL ovf_set_wins: got %b/%b expected 0001", ovf_s, ovf_w);
    end
    in_valid = 1'b0; tick(); ovf_clr = 1'b0;
    n_checks++;
    if (ovf_s !== 4'b0000 || ovf_w !== 4'b0000) begin
      n_fail++; $display("FAIL ovf_clear: got %b/%b expected 0000", ovf_s, ovf_w);
    end
  endtask

  task automatic test_acc();
    mode = 2'd2; top = rep(16'h0100); mux = rep(16'h0010);
    for (int i = 0; i < AL; i++) begin
      in_valid = 1'b1; tick();
      if (i == 0) begin
        mode = 2'd0; top = rep(16'h7777);
      end
      in_valid = 1'b0;
      if (i < AL - 1) begin
        n_checks++;
        if (vld_s !== 1'b0 || busy_s !== 1'b1) begin
          n_fail++; $display("FAIL acc_beat%0d: got vld %b busy %b expected 0/1", i, vld_s, busy_s);
        end
      end
      if (i == 1) begin
        tick(); tick();
      end
    end
    n_checks++;
    if (out_s !== rep(16'h0140) || vld_s !== 1'b1 || busy_s !== 1'b0) begin
      n_fail++; $display("FAIL acc_result: got %h/%b/%b expected %h/1/0", out_s, vld_s, busy_s,
                         rep(16'h0140));
    end
    n_checks++;
    if (out_w !== rep(16'h0140)) begin
      n_fail++; $display("FAIL acc_result_wrap: got %h expected %h", out_w, rep(16'h0140));
    end
    tick();
    mode = 2'd1;
  endtask

  task automatic test_acc_clr();
    mode = 2'd2; top = rep(16'h0100); mux = rep(16'h0010);
    in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
    acc_clr = 1'b1; tick();
    n_checks++;
    if (busy_s !== 1'b0 || vld_s !== 1'b0 || out_s !== rep(16'h0140)) begin
      n_fail++; $display("FAIL acc_clr: got busy %b vld %b out %h expected 0/0/%h",
                         busy_s, vld_s, out_s, rep(16'h0140));
    end
    in_valid = 1'b1; tick();
    n_checks++;
    if (busy_s !== 1'b0) begin
      n_fail++; $display("FAIL acc_clr_drop: got busy %b expected 0", busy_s);
    end
    acc_clr = 1'b0; top = rep(16'h0200);
    for (int i = 0; i < AL; i++) begin
      tick();
      if (i < AL - 1) begin
        n_checks++;
        if (vld_s !== 1'b0) begin
          n_fail++; $display("FAIL acc_fresh_beat%0d: got vld %b expected 0", i, vld_s);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_s !== rep(16'h0240) || vld_s !== 1'b1) begin
      n_fail++; $display("FAIL acc_fresh: got %h/%b expected %h/1", out_s, vld_s, rep(16'h0240));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    mode = 2'd2; top = rep(16'h0100); mux = rep(16'h0010);
    in_valid = 1'b1; tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({out_s, vld_s, ovf_s, en_s, busy_s} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got %h expected 0", {out_s, vld_s, ovf_s, en_s, busy_s});
    end
    en_ld = 1'b1; en_lane = 4'b1111; tick(); en_ld = 1'b0;
    mode = 2'd3; top = rep(16'h0001); mux = rep(16'h0002); in_valid = 1'b1; tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_s !== rep(16'h0003) || vld_s !== 1'b1) begin
      n_fail++; $display("FAIL add_after_reset: got %h/%b expected %h/1", out_s, vld_s,
                         rep(16'h0003));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      in_valid = ($urandom_range(0, 9) < 7);
      mode     = 2'($urandom_range(0, 3));
      en_ld    = ($urandom_range(0, 9) < 2);
      en_lane  = 4'($urandom);
      acc_clr  = ($urandom_range(0, 99) < 5);
      ovf_clr  = ($urandom_range(0, 9) == 0);
      top      = {$urandom, $urandom};
      mux      = {$urandom, $urandom};
      tick();
      n_checks++;
      if (out_s !== m_out[0] || out_w !== m_out[1]) begin
        n_fail++; $display("FAIL rnd_data[%0d]: got %h/%h expected %h/%h", i, out_s, out_w,
                           m_out[0], m_out[1]);
      end
      n_checks++;
      if (vld_s !== m_vld || vld_w !== m_vld) begin
        n_fail++; $display("FAIL rnd_valid[%0d]: got %b/%b expected %b", i, vld_s, vld_w, m_vld);
      end
      n_checks++;
      if (ovf_s !== m_ovf[0] || ovf_w !== m_ovf[1]) begin
        n_fail++; $display("FAIL rnd_ovf[%0d]: got %b/%b expected %b/%b", i, ovf_s, ovf_w,
                           m_ovf[0], m_ovf[1]);
      end
      n_checks++;
      if (en_s !== m_en || busy_s !== (m_cnt != 0) || busy_w !== (m_cnt != 0)) begin
        n_fail++; $display("FAIL rnd_en_busy[%0d]: got %b/%b expected %b/%b", i, en_s, busy_s,
                           m_en, (m_cnt != 0));
      end
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_overflow();
    test_acc();
    test_acc_clr();
    test_reset_mid();
    test_random();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
